// File: rtl/th_second_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | th_second_stage_if : external memory read bus (request/accept/data) |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface th_second_stage_if #(
    parameter int ADDRESS = 10
);
    logic               m_read_o;
    logic               m_rack_i;
    logic               m_ready_i;
    logic [ADDRESS-1:0] m_addr_o;
    logic [31:0]        m_data_i;

    modport master (
        output m_read_o, m_addr_o,
        input  m_rack_i, m_ready_i, m_data_i
    );

    modport slave (
        input  m_read_o, m_addr_o,
        output m_rack_i, m_ready_i, m_data_i
    );
endinterface
`default_nettype wire

// File: rtl/th_second_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | th_second_stage : fetch stage 2, 2x8-word I-cache data RAM, line fill|
// | rev 1.0  option macro: TH_SECOND_CRITICAL_FIRST_EN                  |
// +--------------------------------------------------------------------+
module th_second_stage #(
    parameter int ADDRESS = 10
) (
    input  wire logic              clock,
    input  wire logic              reset_n,
    input  wire logic              enable_i,
    th_second_stage_if.master      mem,
    input  wire logic              if_lookup_i,
    input  wire logic [3:0]        if_l_addr_i,
    input  wire logic              if_packed_i,
    output logic                   if_ack_o,
    input  wire logic              if_hit_i,
    input  wire logic              if_miss_i,
    input  wire logic [ADDRESS-1:0] if_pc_i,
    output logic                   if_busy_o,
    output logic                   if_update_o,
    output logic [3:0]             if_u_addr_o,
    output logic                   if_packed_o,
    output logic                   br_update_o,
    output logic [ADDRESS-4:0]     br_newtag_o,
    output logic                   br_lru_no,
    output logic                   br_bank_o,
    output logic [30:0]            de_instr_o,
    output logic                   de_valid_o,
    output logic                   de_nop_o
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        DRAIN   = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic               lru;
    logic               bank;
    logic [ADDRESS-1:0] pc_q;
    logic [2:0]         acc;
    logic [2:0]         rcnt;
    logic [2:0]         offs;
    logic [2:0]         wr_word;
    logic               capture;
    logic               line_done;
    logic               take_hit;
    logic               take_miss;
    logic [31:0]        cache [16];
    logic [31:0]        hit_word;
    logic [31:0]        deliver_word;
    logic               unused_inputs;

`ifdef TH_SECOND_CRITICAL_FIRST_EN
    assign offs = pc_q[2:0];
    localparam state_t LINE_DONE_STATE = IDLE;
`else
    assign offs = 3'd0;
    localparam state_t LINE_DONE_STATE = DELIVER;
`endif

    assign wr_word      = rcnt + offs;
    assign capture      = enable_i && (state == FILL || state == DRAIN) && mem.m_ready_i;
    assign line_done    = capture && (rcnt == 3'd7);
    assign hit_word     = cache[if_l_addr_i];
    assign deliver_word = cache[{bank, pc_q[2:0]}];

    // Request is gated by enable so a frozen stage never leaves an uncounted accept.
    assign mem.m_read_o = enable_i && (state == FILL);
    assign mem.m_addr_o = {pc_q[ADDRESS-1:3], acc + offs};

    assign unused_inputs = &{1'b0, if_packed_i};

    always_comb begin
        state_nxt = state;
        if_ack_o  = 1'b0;
        take_hit  = 1'b0;
        take_miss = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i && if_lookup_i) begin
                    if (if_miss_i) begin
                        if_ack_o  = 1'b1;
                        take_miss = 1'b1;
                        state_nxt = FILL;
                    end else if (if_hit_i) begin
                        if_ack_o  = 1'b1;
                        take_hit  = 1'b1;
                    end
                end
            end
            FILL: begin
                if (line_done)
                    state_nxt = LINE_DONE_STATE;
                else if (enable_i && mem.m_rack_i && acc == 3'd7)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (line_done)
                    state_nxt = LINE_DONE_STATE;
            end
            DELIVER: begin
                if (enable_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset_n && capture)
            cache[{bank, wr_word}] <= mem.m_data_i;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            lru         <= 1'b0;
            bank        <= 1'b0;
            pc_q        <= '0;
            acc         <= 3'd0;
            rcnt        <= 3'd0;
            if_busy_o   <= 1'b0;
            if_update_o <= 1'b0;
            if_u_addr_o <= 4'd0;
            if_packed_o <= 1'b0;
            br_update_o <= 1'b0;
            br_newtag_o <= '0;
            br_lru_no   <= 1'b0;
            br_bank_o   <= 1'b0;
            de_instr_o  <= 31'd0;
            de_valid_o  <= 1'b0;
            de_nop_o    <= 1'b0;
        end else begin
            state       <= state_nxt;
            de_valid_o  <= 1'b0;
            de_nop_o    <= 1'b0;
            if_update_o <= 1'b0;
            br_update_o <= 1'b0;
            if (enable_i) begin
                if (take_hit) begin
                    de_valid_o <= 1'b1;
                    de_instr_o <= hit_word[30:0];
                    de_nop_o   <= (hit_word == 32'd0);
                    lru        <= ~if_l_addr_i[3];
                end
                if (take_miss) begin
                    pc_q      <= if_pc_i;
                    bank      <= lru;
                    acc       <= 3'd0;
                    rcnt      <= 3'd0;
                    if_busy_o <= 1'b1;
                end
                if (state == FILL && mem.m_rack_i)
                    acc <= acc + 3'd1;
                if (capture) begin
                    rcnt        <= rcnt + 3'd1;
                    if_update_o <= 1'b1;
                    if_u_addr_o <= {bank, wr_word};
                    if_packed_o <= mem.m_data_i[28];
`ifdef TH_SECOND_CRITICAL_FIRST_EN
                    // First returned word is the one that missed: forward it straight to decode.
                    if (rcnt == 3'd0) begin
                        de_valid_o <= 1'b1;
                        de_instr_o <= mem.m_data_i[30:0];
                        de_nop_o   <= (mem.m_data_i == 32'd0);
                    end
`endif
                end
                if (line_done) begin
                    br_update_o <= 1'b1;
                    br_newtag_o <= pc_q[ADDRESS-1:3];
                    br_bank_o   <= bank;
                    br_lru_no   <= ~bank;
                    lru         <= ~bank;
`ifdef TH_SECOND_CRITICAL_FIRST_EN
                    if_busy_o   <= 1'b0;
`endif
                end
                if (state == DELIVER) begin
                    de_valid_o <= 1'b1;
                    de_instr_o <= deliver_word[30:0];
                    de_nop_o   <= (deliver_word == 32'd0);
                    if_busy_o  <= 1'b0;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_th_second_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_th_second_stage : directed bench for the fetch second stage      |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_th_second_stage;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable_i;
    logic        if_lookup_i;
    logic [3:0]  if_l_addr_i;
    logic        if_packed_i;
    logic        if_ack_o;
    logic        if_hit_i;
    logic        if_miss_i;
    logic [9:0]  if_pc_i;
    logic        if_busy_o;
    logic        if_update_o;
    logic [3:0]  if_u_addr_o;
    logic        if_packed_o;
    logic        br_update_o;
    logic [6:0]  br_newtag_o;
    logic        br_lru_no;
    logic        br_bank_o;
    logic [30:0] de_instr_o;
    logic        de_valid_o;
    logic        de_nop_o;

    int tests = 0;
    int fails = 0;
    logic [31:0] words [8];

    th_second_stage_if #(.ADDRESS(10)) mem ();

    th_second_stage #(.ADDRESS(10)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable_i    (enable_i),
        .mem         (mem),
        .if_lookup_i (if_lookup_i),
        .if_l_addr_i (if_l_addr_i),
        .if_packed_i (if_packed_i),
        .if_ack_o    (if_ack_o),
        .if_hit_i    (if_hit_i),
        .if_miss_i   (if_miss_i),
        .if_pc_i     (if_pc_i),
        .if_busy_o   (if_busy_o),
        .if_update_o (if_update_o),
        .if_u_addr_o (if_u_addr_o),
        .if_packed_o (if_packed_o),
        .br_update_o (br_update_o),
        .br_newtag_o (br_newtag_o),
        .br_lru_no   (br_lru_no),
        .br_bank_o   (br_bank_o),
        .de_instr_o  (de_instr_o),
        .de_valid_o  (de_valid_o),
        .de_nop_o    (de_nop_o)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        reset_n = 1'b0; enable_i = 1'b1;
        if_lookup_i = 1'b0; if_l_addr_i = 4'd0; if_packed_i = 1'b0;
        if_hit_i = 1'b0; if_miss_i = 1'b0; if_pc_i = 10'd0;
        mem.m_rack_i = 1'b0; mem.m_ready_i = 1'b0; mem.m_data_i = 32'd0;
        step(); step();
        outs = {mem.m_read_o, mem.m_addr_o, if_ack_o, if_update_o, if_u_addr_o, if_packed_o,
                br_update_o, br_newtag_o, br_lru_no, br_bank_o, de_instr_o, de_valid_o, de_nop_o};
        tests++;
        if (outs !== 64'd0) begin
            fails++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        tests++;
        if (if_busy_o !== 1'b0) begin
            fails++; $display("FAIL reset_busy: got %b expected 0", if_busy_o);
        end
        reset_n = 1'b1;
    endtask

    // Miss (with hit also raised: miss must win), then serve the line with a
    // one-cycle-latency memory. Optionally pokes a hit lookup mid-fill.
    task automatic test_miss(input string name, input logic [9:0] pc, input logic exp_bank, input logic probe);
        int n_acc = 0, n_upd = 0, n_br = 0, n_pk = 0, exp_pk = 0;
        int bad_addr = 0, bad_upd = 0, bad_br = 0;
        logic pend = 1'b0, nxt;
        logic [2:0] pend_w = 3'd0;
        logic got_de = 1'b0;
        for (int k = 0; k < 8; k++) exp_pk += int'(words[k][28]);
        if_lookup_i = 1'b1; if_miss_i = 1'b1; if_hit_i = 1'b1; if_pc_i = pc; if_l_addr_i = 4'd0;
        #1;
        tests++;
        if (if_ack_o !== 1'b1) begin
            fails++; $display("FAIL %s_ack: got %b expected 1", name, if_ack_o);
        end
        step();
        if_lookup_i = 1'b0; if_miss_i = 1'b0; if_hit_i = 1'b0;
        tests++;
        if (if_busy_o !== 1'b1 || de_valid_o !== 1'b0) begin
            fails++; $display("FAIL %s_busy: got busy=%b valid=%b expected busy=1 valid=0", name, if_busy_o, de_valid_o);
        end
        for (int cyc = 0; cyc < 40 && !got_de; cyc++) begin
            if (if_update_o) begin
                if (if_u_addr_o !== {exp_bank, 3'(n_upd)}) bad_upd++;
                if (if_packed_o !== words[if_u_addr_o[2:0]][28]) bad_upd++;
                if (if_packed_o) n_pk++;
                n_upd++;
            end
            if (br_update_o) begin
                n_br++;
                if (br_newtag_o !== pc[9:3] || br_bank_o !== exp_bank || br_lru_no !== ~exp_bank) bad_br++;
            end
            if (de_valid_o) begin
                got_de = 1'b1;
                tests++;
                if (de_instr_o !== words[pc[2:0]][30:0]) begin
                    fails++; $display("FAIL %s_instr: got %h expected %h", name, de_instr_o, words[pc[2:0]][30:0]);
                end
                tests++;
                if (de_nop_o !== (words[pc[2:0]] == 32'd0)) begin
                    fails++; $display("FAIL %s_nop: got %b expected %b", name, de_nop_o, words[pc[2:0]] == 32'd0);
                end
            end else begin
                mem.m_ready_i = pend;
                mem.m_data_i  = pend ? words[pend_w] : 32'd0;
                mem.m_rack_i  = 1'b1;
                if (probe && cyc == 3) begin
                    if_lookup_i = 1'b1; if_hit_i = 1'b1; if_l_addr_i = 4'd1;
                end
                #1;
                if (probe && cyc == 3) begin
                    tests++;
                    if (if_ack_o !== 1'b0) begin
                        fails++; $display("FAIL %s_busy_ack: got %b expected 0", name, if_ack_o);
                    end
                end
                nxt = 1'b0;
                if (mem.m_read_o) begin
                    if (mem.m_addr_o !== {pc[9:3], 3'(n_acc)}) bad_addr++;
                    pend_w = mem.m_addr_o[2:0];
                    nxt = 1'b1;
                    n_acc++;
                end
                pend = nxt;
                step();
                if_lookup_i = 1'b0; if_hit_i = 1'b0;
            end
        end
        mem.m_rack_i = 1'b0; mem.m_ready_i = 1'b0; mem.m_data_i = 32'd0;
        tests++;
        if (!got_de) begin
            fails++; $display("FAIL %s_deliver_timeout: got no de_valid expected one within 40 cycles", name);
        end
        tests++;
        if (n_acc != 8 || bad_addr != 0) begin
            fails++; $display("FAIL %s_addr: got %0d accepts %0d bad expected 8 accepts 0 bad", name, n_acc, bad_addr);
        end
        tests++;
        if (n_upd != 8 || bad_upd != 0 || n_pk != exp_pk) begin
            fails++; $display("FAIL %s_update: got %0d pulses %0d bad %0d packed expected 8 pulses 0 bad %0d packed",
                              name, n_upd, bad_upd, n_pk, exp_pk);
        end
        tests++;
        if (n_br != 1 || bad_br != 0) begin
            fails++; $display("FAIL %s_tag: got %0d pulses %0d bad expected 1 pulse 0 bad", name, n_br, bad_br);
        end
        tests++;
        if (if_busy_o !== 1'b0) begin
            fails++; $display("FAIL %s_busy_clear: got %b expected 0", name, if_busy_o);
        end
        step();
    endtask

    task automatic test_hit(input string name, input logic [3:0] la, input logic [30:0] exp_instr, input logic exp_nop);
        if_lookup_i = 1'b1; if_hit_i = 1'b1; if_l_addr_i = la;
        #1;
        tests++;
        if (if_ack_o !== 1'b1) begin
            fails++; $display("FAIL %s_ack: got %b expected 1", name, if_ack_o);
        end
        step();
        if_lookup_i = 1'b0; if_hit_i = 1'b0;
        tests++;
        if (de_valid_o !== 1'b1 || de_instr_o !== exp_instr || de_nop_o !== exp_nop) begin
            fails++; $display("FAIL %s_data: got v=%b i=%h n=%b expected v=1 i=%h n=%b",
                              name, de_valid_o, de_instr_o, de_nop_o, exp_instr, exp_nop);
        end
        step();
    endtask

    task automatic test_enable_low();
        enable_i = 1'b0; if_lookup_i = 1'b1; if_hit_i = 1'b1; if_l_addr_i = 4'd1;
        #1;
        tests++;
        if (if_ack_o !== 1'b0) begin
            fails++; $display("FAIL enable_low_ack: got %b expected 0", if_ack_o);
        end
        step();
        tests++;
        if (de_valid_o !== 1'b0) begin
            fails++; $display("FAIL enable_low_valid: got %b expected 0", de_valid_o);
        end
        enable_i = 1'b1; if_lookup_i = 1'b0; if_hit_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_fill();
        int n_br = 0, n_rd = 0;
        if_lookup_i = 1'b1; if_miss_i = 1'b1; if_pc_i = 10'd16;
        step();
        if_lookup_i = 1'b0; if_miss_i = 1'b0;
        mem.m_rack_i = 1'b1;
        step(); step(); step();
        reset_n = 1'b0;
        step();
        tests++;
        if (mem.m_read_o !== 1'b0 || if_busy_o !== 1'b0) begin
            fails++; $display("FAIL reset_mid_fill_read: got read=%b busy=%b expected 0 0", mem.m_read_o, if_busy_o);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (br_update_o) n_br++;
            if (mem.m_read_o) n_rd++;
            step();
        end
        mem.m_rack_i = 1'b0;
        tests++;
        if (n_br != 0 || n_rd != 0) begin
            fails++; $display("FAIL reset_mid_fill_quiet: got %0d tag pulses %0d reads expected 0 0", n_br, n_rd);
        end
    endtask

    initial begin
        test_reset();
        step();
        for (int k = 0; k < 8; k++) words[k] = 32'd0;
        words[1] = 32'h1000_0000;
        words[2] = 32'h1000_0000;
        test_miss("miss_pc0", 10'd0, 1'b0, 1'b0);
        test_hit("hit_w0", 4'd0, 31'd0, 1'b1);
        test_hit("hit_w1", 4'd1, 31'h1000_0000, 1'b0);
        test_enable_low();
        for (int k = 0; k < 8; k++)
            words[k] = k[0] ? (32'h8000_0000 | (32'(k) << 4)) : (32'h1234_5600 + 32'(k));
        test_miss("miss_pc11", 10'd11, 1'b1, 1'b1);
        test_hit("hit_b1w3", 4'd11, 31'h0000_0030, 1'b0);
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/th_second_stage.md
Name: th_second_stage

Overview:
- Second stage of the TTA instruction-fetch pipeline. Sits between the first (tag-lookup) stage and the decode stage.
- Holds a 2-bank x 8-word instruction cache data RAM.
- On a hit, it delivers the cached word to decode. On a miss, it fills an 8-word line from external memory, reports packed flags and the new tag back upstream, then delivers the missed instruction.

Parameters:
- ADDRESS, 10, word-address width of m_addr_o and if_pc_i. Tag width is ADDRESS-3.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- enable_i  in  1  stage enable; low freezes all state and holds outputs
- m_read_o  out  1  memory read request
- m_rack_i  in  1  read-address accept, same cycle as m_read_o
- m_ready_i  in  1  read data valid
- m_addr_o  out  ADDRESS  memory word address
- m_data_i  in  32  read data
- if_lookup_i  in  1  first stage presents a lookup result this cycle
- if_l_addr_i  in  4  cache word index: bit3 = bank, bits2:0 = word
- if_packed_i  in  1  packed flag of the looked-up word
- if_ack_o  out  1  lookup accepted
- if_hit_i  in  1  lookup hit
- if_miss_i  in  1  lookup miss
- if_pc_i  in  ADDRESS  PC of the lookup
- if_busy_o  out  1  line fill in progress
- if_update_o  out  1  packed-flag table write strobe
- if_u_addr_o  out  4  packed-flag table index {bank, word}
- if_packed_o  out  1  packed flag to write
- br_update_o  out  1  tag write strobe, one cycle
- br_newtag_o  out  ADDRESS-3  new tag, if_pc_i[ADDRESS-1:3] of the miss
- br_lru_no  out  1  new LRU bank (the bank not just filled)
- br_bank_o  out  1  bank being filled
- de_instr_o  out  31  instruction to decode, word[30:0]
- de_valid_o  out  1  de_instr_o valid
- de_nop_o  out  1  delivered slot is a bubble/NOP

Behaviour:
- Reset values:
  - All outputs 0. State IDLE. LRU bank 0.
  - Cache RAM contents are not cleared.
- States: IDLE, FILL, DRAIN, DELIVER.
- IDLE, lookup with hit and enable_i high:
  - if_ack_o=1 combinationally.
  - Next cycle: de_valid_o=1, de_instr_o=cache[if_l_addr_i][30:0], de_nop_o=(word==0).
  - LRU bank becomes ~if_l_addr_i[3].
- IDLE, lookup with miss:
  - if_ack_o=1 that cycle.
  - Latch pc and fill bank = current LRU bank.
  - Go to FILL; if_busy_o=1 from the next cycle until return to IDLE.
- FILL:
  - m_read_o=1, m_addr_o={pc[ADDRESS-1:3], cnt}, cnt starting at 0.
  - cnt increments on each cycle with m_rack_i=1.
  - After the 8th accept: deassert m_read_o and go to DRAIN.
- Data capture (FILL or DRAIN):
  - Each m_ready_i=1 cycle writes m_data_i into cache[{bank, rcnt}] and increments rcnt.
  - Same cycle, registered one cycle later: if_update_o=1, if_u_addr_o={bank, rcnt}, if_packed_o=m_data_i[28].
- Line complete, after the 8th ready:
  - One-cycle br_update_o=1, br_newtag_o=pc[ADDRESS-1:3], br_bank_o=bank, br_lru_no=~bank.
  - Go to DELIVER.
- DELIVER:
  - de_valid_o=1 for one cycle with cache[{bank, pc[2:0]}][30:0].
  - Clear if_busy_o; return to IDLE.
- Lookups while busy: if_ack_o=0. The first stage must hold the request.
- Simultaneous if_hit_i and if_miss_i: miss wins.
- enable_i low: no state, counter or RAM change; strobes held low.
- Reset mid-fill: abort immediately, drop m_read_o, no tag update.

Optional Feature:
- Macro TH_SECOND_CRITICAL_FIRST_EN.
- Defined:
  - FILL starts at word pc[2:0] and wraps modulo 8.
  - The missed word is forwarded to decode (de_valid_o=1) the cycle after its m_ready_i.
  - DELIVER is skipped.
- Undefined: fill order 0..7; delivery in DELIVER as above.

Test Plan:
- Reset: reset_n low 2 cycles -> all outputs 0, if_busy_o=0.
- Miss at pc=0, memory words 0..7 with words 1,2 = 0x1000_0000 and the rest 0:
  - m_addr_o steps 0..7 with 8 accepts.
  - if_update_o 8 pulses, if_packed_o=1 only for u_addr 1,2.
  - br_update_o pulse: newtag 0, bank 0, lru_n 1.
  - de_valid_o with instr 0, de_nop_o=1.
- Hit with l_addr=1 after the fill -> next cycle de_valid_o=1, de_instr_o=31'h1000_0000, de_nop_o=0; LRU bank becomes 1.
- Lookup during FILL -> if_ack_o=0, no disturbance to the fill.
- Second miss at pc=8 -> fills bank 1; br_newtag_o=1, br_lru_no=0.
- Reset mid-fill -> m_read_o=0 next edge, no br_update_o.
